hazard_scoreboard: RTL

//  Parametrised successor to the ID-stage hazard detector. Per-register

---
 rtl/hazard_scoreboard_if.sv | 32 +++
 rtl/hazard_scoreboard.sv | 114 +++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard bundle. The decode stage (master) presents the
// instruction being decoded; the scoreboard (slave) answers with the stall
// request and the per-operand bypass-select flags.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 3
);
  logic              id_valid_i;
  logic [ADDR_W-1:0] id_rs1_i;
  logic [ADDR_W-1:0] id_rs2_i;
  logic              id_rs1_use_i;
  logic              id_rs2_use_i;
  logic [ADDR_W-1:0] id_rd_i;
  logic              id_rd_we_i;
  logic [CNT_W-1:0]  id_lat_i;
  logic              flush_i;
  logic              stall_o;
  logic              fwd_rs1_o;
  logic              fwd_rs2_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
           id_rd_i, id_rd_we_i, id_lat_i, flush_i,
    input  stall_o, fwd_rs1_o, fwd_rs2_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
           id_rd_i, id_rd_we_i, id_lat_i, flush_i,
    output stall_o, fwd_rs1_o, fwd_rs2_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard between decode and issue. Each tracked
// register holds the number of cycles until its in-flight result reaches the
// bypass bus. Decode is stalled on RAW/WAW hazards, operands whose producer
// is exactly one cycle out are flagged for bypass, and stalled cycles are
// counted in a saturating counter. Register 0 is hardwired and never tracked.
module hazard_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 5,
  parameter int MAX_LAT     = 4,
  parameter int FWD_EN      = 1,
  parameter int STALL_CNT_W = 16,
  parameter int CNT_W       = $clog2(MAX_LAT + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  hazard_scoreboard_if.slave     id,
  output logic [NUM_REGS-1:0]    busy_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] MaxLat = CNT_W'(MAX_LAT);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  logic [CNT_W-1:0]       cnt_q [NUM_REGS];
  logic [CNT_W-1:0]       cnt_d [NUM_REGS];
  logic [STALL_CNT_W-1:0] stallCnt_q;
  logic [STALL_CNT_W-1:0] stallCnt_d;

  logic [CNT_W-1:0] rs1Cnt;
  logic [CNT_W-1:0] rs2Cnt;
  logic [CNT_W-1:0] rdCnt;
  logic [CNT_W-1:0] latEff;
  logic             rs1Active;
  logic             rs2Active;
  logic             rdActive;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             fwd1;
  logic             fwd2;
  logic             stall;
  logic             issue;

  // Fetch the pending counts of the registers named by the decode instruction;
  // addresses outside the tracked range, and register 0, read as idle.
  always_comb begin
    rs1Cnt = '0;
    rs2Cnt = '0;
    rdCnt  = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (id.id_rs1_i == ADDR_W'(r)) rs1Cnt = cnt_q[r];
      if (id.id_rs2_i == ADDR_W'(r)) rs2Cnt = cnt_q[r];
      if (id.id_rd_i  == ADDR_W'(r)) rdCnt  = cnt_q[r];
    end
  end

  // Classify hazards from the counts as they stand before this cycle's
  // registration, so an instruction never hazards against its own write.
  always_comb begin
    latEff    = (id.id_lat_i > MaxLat) ? MaxLat : id.id_lat_i;
    rs1Active = id.id_valid_i && id.id_rs1_use_i && (id.id_rs1_i != '0);
    rs2Active = id.id_valid_i && id.id_rs2_use_i && (id.id_rs2_i != '0);
    rdActive  = id.id_valid_i && id.id_rd_we_i && (id.id_rd_i != '0);
    if (FWD_EN != 0) begin
      raw1 = rs1Active && (rs1Cnt > One);
      raw2 = rs2Active && (rs2Cnt > One);
      fwd1 = rs1Active && (rs1Cnt == One);
      fwd2 = rs2Active && (rs2Cnt == One);
    end else begin
      raw1 = rs1Active && (rs1Cnt != '0);
      raw2 = rs2Active && (rs2Cnt != '0);
      fwd1 = 1'b0;
      fwd2 = 1'b0;
    end
    waw   = rdActive && (rdCnt > latEff);
    stall = (raw1 || raw2 || waw) && !id.flush_i;
    issue = rdActive && !stall && !id.flush_i && (latEff != '0);
  end

  assign id.stall_o   = stall;
  assign id.fwd_rs1_o = fwd1;
  assign id.fwd_rs2_o = fwd2;

  // Drain every pending count by one; a fresh issue overwrites its
  // destination's count with the clamped latency instead.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r]  = (cnt_q[r] != '0) ? (cnt_q[r] - One) : '0;
      busy_o[r] = (cnt_q[r] != '0);
      if (issue && (r != 0) && (id.id_rd_i == ADDR_W'(r))) cnt_d[r] = latEff;
    end
    cnt_d[0] = '0;
  end

  // Count stalled cycles, holding once the counter is all-ones.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (stall && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + STALL_CNT_W'(1);
  end

  assign stall_cnt_o = stallCnt_q;

  // State registers; reset wipes all pending writes at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      stallCnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

endmodule
